// File: rtl/key_dispenser.sv
// key_dispenser: sweeps [KEY_LOWER, KEY_UPPER] once and hands each key out
// exactly once to NUM_CH cores via a round-robin request/grant handshake.
// The sweep stops on exhaustion or halt and restarts only on a start edge.
module key_dispenser #(
  parameter int                KEY_W     = 24,
  parameter int                NUM_CH    = 4,
  parameter logic [KEY_W-1:0]  KEY_LOWER = '0,
  parameter logic [KEY_W-1:0]  KEY_UPPER = {KEY_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [KEY_W-1:0]  key_o,
  output logic              last_o,
  output logic              busy,
  output logic              exhausted,
  output logic              halted
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    EXHAUSTED = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                start_q;
  logic                start_edge;
  logic                restart;
  logic [KEY_W-1:0]    next_key;
  logic                at_upper;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [PTR_W-1:0]    sel_idx;
  logic                sel_vld;
  logic [NUM_CH-1:0]   eligible;
  logic                dispense_p0;
  logic [NUM_CH-1:0]   gnt_p0;

  // A channel whose grant is on the wire this cycle is masked so a requester
  // that is still dropping req cannot be granted twice.
  assign start_edge  = start & ~start_q;
  assign restart     = start_edge && (state != RUN);
  assign eligible    = req & ~gnt;
  assign at_upper    = (next_key == KEY_UPPER);
  assign dispense_p0 = (state == RUN) && !halt && sel_vld;

  // Previous start level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: halt beats any request, the last key ends the sweep
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, EXHAUSTED, HALTED: if (start_edge) state_nxt = RUN;
      RUN: begin
        if (halt)                     state_nxt = HALTED;
        else if (sel_vld && at_upper) state_nxt = EXHAUSTED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy      = (state == RUN);
    exhausted = (state == EXHAUSTED);
    halted    = (state == HALTED);
  end

  // Round-robin pick: scan from the priority pointer upward, first eligible wins
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (eligible[idx]) begin
        sel_vld = 1'b1;
        sel_idx = PTR_W'(idx);
      end
    end
  end

  // One-hot grant vector and the pointer that follows the granted channel
  always_comb begin
    gnt_p0 = '0;
    if (dispense_p0) gnt_p0[sel_idx] = 1'b1;
    ptr_nxt = (sel_idx == PTR_W'(NUM_CH - 1)) ? '0 : sel_idx + PTR_W'(1);
  end

  // Key counter and arbitration pointer; the counter never steps past KEY_UPPER
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      next_key <= KEY_LOWER;
      ptr      <= '0;
    end else if (dispense_p0) begin
      ptr <= ptr_nxt;
      if (!at_upper) next_key <= next_key + KEY_W'(1);
    end
  end

  // ---- stage p0 -> p1: registered grant, key and last flag ----
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt    <= '0;
      key_o  <= '0;
      last_o <= 1'b0;
    end else begin
      gnt    <= gnt_p0;
      last_o <= dispense_p0 && at_upper;
      if (dispense_p0) key_o <= next_key;
    end
  end

endmodule

// File: tb/tb_key_dispenser.sv
// Directed bench for key_dispenser: a small-range instance (keys 0..5) and a
// single-key instance at the top of the 24-bit space.
module tb_key_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, start1, halt1;
  logic [3:0]  req, req1;
  logic [3:0]  gnt, gnt1;
  logic [23:0] key_o, key_o1;
  logic        last_o, busy, exhausted, halted;
  logic        last_o1, busy1, exhausted1, halted1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_dispenser #(.KEY_W(24), .NUM_CH(4), .KEY_LOWER(24'd0), .KEY_UPPER(24'd5)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .req(req),
    .gnt(gnt), .key_o(key_o), .last_o(last_o), .busy(busy),
    .exhausted(exhausted), .halted(halted)
  );

  key_dispenser #(.KEY_W(24), .NUM_CH(4), .KEY_LOWER(24'hFFFFFF), .KEY_UPPER(24'hFFFFFF)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .halt(halt1), .req(req1),
    .gnt(gnt1), .key_o(key_o1), .last_o(last_o1), .busy(busy1),
    .exhausted(exhausted1), .halted(halted1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; req = 4'b0000;
    start1 = 1'b0; halt1 = 1'b0; req1 = 4'b0000;
    repeat (3) tick();

    // Reset state
    check_val("rst_gnt",  32'(gnt), 32'd0);
    check_val("rst_key",  32'(key_o), 32'd0);
    check_val("rst_last", 32'(last_o), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_exh",  32'(exhausted), 32'd0);
    check_val("rst_halt", 32'(halted), 32'd0);

    // 1: single requester held high, grants every other cycle, keys 0..5
    reset = 1'b0; tick();
    start = 1'b1; req = 4'b0001;
    tick();
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_nogntyet", 32'(gnt), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("t1_gnt", 32'(gnt), 32'd1);
      check_val("t1_key", 32'(key_o), 32'(k));
      check_val("t1_last", 32'(last_o), 32'(k == 5));
      if (k < 5) begin
        tick();
        check_val("t1_gap", 32'(gnt), 32'd0);
      end
    end
    check_val("t1_exh", 32'(exhausted), 32'd1);
    check_val("t1_notbusy", 32'(busy), 32'd0);
    repeat (3) begin
      tick();
      check_val("t1_after_gnt", 32'(gnt), 32'd0);
      check_val("t1_after_exh", 32'(exhausted), 32'd1);
    end

    // 2: all four requesting, rotation 0,1,2,3,0,1 with consecutive keys
    start = 1'b0; req = 4'b0000; tick();
    start = 1'b1; req = 4'b1111; tick();
    check_val("t2_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("t2_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      check_val("t2_key", 32'(key_o), 32'(k));
      check_val("t2_last", 32'(last_o), 32'(k == 5));
    end
    check_val("t2_exh", 32'(exhausted), 32'd1);
    tick();
    check_val("t2_after_gnt", 32'(gnt), 32'd0);

    // 3: halt together with pending requests; restart resets pointer and key
    start = 1'b0; req = 4'b0000; tick();
    start = 1'b1; req = 4'b1111; tick();
    tick();
    check_val("t3_first_gnt", 32'(gnt), 32'd1);
    check_val("t3_first_key", 32'(key_o), 32'd0);
    halt = 1'b1;
    tick();
    check_val("t3_halt_gnt", 32'(gnt), 32'd0);
    check_val("t3_halted", 32'(halted), 32'd1);
    check_val("t3_notbusy", 32'(busy), 32'd0);
    tick();
    check_val("t3_hold_gnt", 32'(gnt), 32'd0);
    check_val("t3_hold_halted", 32'(halted), 32'd1);
    halt = 1'b0; start = 1'b0; tick();
    start = 1'b1; tick();
    check_val("t3_rs_busy", 32'(busy), 32'd1);
    check_val("t3_rs_unhalted", 32'(halted), 32'd0);
    tick();
    check_val("t3_rs_gnt", 32'(gnt), 32'd1);
    check_val("t3_rs_key", 32'(key_o), 32'd0);

    // 4: reset mid-sweep after key 3
    for (int k = 1; k < 4; k++) begin
      tick();
      check_val("t4_key", 32'(key_o), 32'(k));
    end
    reset = 1'b1; start = 1'b0;
    tick();
    check_val("t4_gnt",  32'(gnt), 32'd0);
    check_val("t4_key0", 32'(key_o), 32'd0);
    check_val("t4_last", 32'(last_o), 32'd0);
    check_val("t4_busy", 32'(busy), 32'd0);
    check_val("t4_exh",  32'(exhausted), 32'd0);
    check_val("t4_hlt",  32'(halted), 32'd0);
    reset = 1'b0; req = 4'b0001;
    tick();
    check_val("t4_idle", 32'(busy), 32'd0);
    check_val("t4_idle_gnt", 32'(gnt), 32'd0);
    start = 1'b1; tick();
    tick();
    check_val("t4_rs_gnt", 32'(gnt), 32'd1);
    check_val("t4_rs_key", 32'(key_o), 32'd0);

    // 5: single-key range at the top of the key space
    start1 = 1'b1; req1 = 4'b0001;
    tick();
    check_val("t5_busy", 32'(busy1), 32'd1);
    tick();
    check_val("t5_gnt", 32'(gnt1), 32'd1);
    check_val("t5_key", 32'(key_o1), 32'hFFFFFF);
    check_val("t5_last", 32'(last_o1), 32'd1);
    check_val("t5_exh", 32'(exhausted1), 32'd1);
    repeat (3) begin
      tick();
      check_val("t5_nogain", 32'(gnt1), 32'd0);
      check_val("t5_last_off", 32'(last_o1), 32'd0);
    end

    // 6: start held through reset release counts once; no restart while held
    reset = 1'b1; start = 1'b1; req = 4'b0001;
    repeat (2) tick();
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check_val("t6_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("t6_key", 32'(key_o), 32'(k));
      check_val("t6_gnt", 32'(gnt), 32'd1);
      if (k < 5) tick();
    end
    check_val("t6_exh", 32'(exhausted), 32'd1);
    repeat (8) begin
      tick();
      check_val("t6_held_gnt", 32'(gnt), 32'd0);
      check_val("t6_held_exh", 32'(exhausted), 32'd1);
    end
    start = 1'b0; tick();
    start = 1'b1; tick();
    check_val("t6_retoggle_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_dispenser.md
# key_dispenser

Multi-channel key source for the parallel RC4 cracking array. It sweeps a parametrised key range `[KEY_LOWER, KEY_UPPER]` once and hands out each key exactly once to `NUM_CH` decryption cores through a round-robin request/grant handshake. It stops when the range is exhausted or when any core reports a hit, and restarts only on a new `start` edge. It sits between the top-level control FSM and the decryption core array.

## Interface

Parameters:
- `KEY_W`, 24: key width in bits.
- `NUM_CH`, 4: number of requesting cores (≥1).
- `KEY_LOWER`, 0: first key of the sweep (`KEY_W` bits).
- `KEY_UPPER`, `2**KEY_W-1`: last key of the sweep. `KEY_LOWER ≤ KEY_UPPER` is required.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: level input. Its rising edge (re)starts a sweep.
- `halt`, in, 1: a core found the key. Stops dispensing.
- `req`, in, `NUM_CH`: per-channel key request. Held high until that channel's `gnt` is seen.
- `gnt`, out, `NUM_CH`: registered, one-hot or zero. One-cycle grant.
- `key_o`, out, `KEY_W`: registered key, valid only while `|gnt`.
- `last_o`, out, 1: high with the grant that carries `KEY_UPPER`.
- `busy`, out, 1: state is RUN.
- `exhausted`, out, 1: state is EXHAUSTED.
- `halted`, out, 1: state is HALTED.

## Operation

- Start edge detection uses internal register `start_q`, which resets to 0.
  - `start_edge = start & ~start_q`.
  - A `start` held high across reset release therefore counts as an edge on the first post-reset cycle.
- States: IDLE, RUN, EXHAUSTED, HALTED. All are registered.
- IDLE:
  - On `start_edge`, go to RUN and load `next_key = KEY_LOWER`.
  - Otherwise stay in IDLE.
- RUN, evaluated each cycle in this priority order:
  - `halt` = 1: go to HALTED. No grant is issued this cycle; `halt` wins over any pending `req`.
  - Else if any eligible `req`: grant one channel, drive `key_o <= next_key`.
    - If `next_key == KEY_UPPER`: set `last_o`, go to EXHAUSTED.
    - Otherwise: `next_key <= next_key + 1`.
  - Eligible means `req[i]` is high and `gnt[i]` is not high in the current cycle. This prevents a double grant while the requester drops `req`.
- The `KEY_UPPER` comparison is equality only. The increment never reaches `2**KEY_W`, so there is no wrap-around within a sweep.
- Round-robin arbitration:
  - Priority pointer starts at channel 0 after reset and after each `start_edge`.
  - After a grant to channel `i`, channel `i+1` (mod `NUM_CH`) has highest priority.
- EXHAUSTED and HALTED:
  - No grants; `gnt` = 0.
  - `start_edge` goes to RUN with `next_key = KEY_LOWER` and the pointer at 0 (full restart).
  - `halt` is ignored.
- `start_edge` while in RUN is ignored.
- Reset, including mid-sweep:
  - State becomes IDLE and `next_key = KEY_LOWER`.
  - All outputs become 0 (`gnt`, `key_o`, `last_o`, `busy`, `exhausted`, `halted`).
  - Any grant in flight is discarded.

## Timing

- `start_edge` sampled at cycle t: `busy` = 1 from t+1.
- `req[i]` high at cycle t while in RUN: `gnt[i]` and `key_o` are valid at t+1. Latency is one cycle.
- Throughput is at most one key per cycle across all channels.
- Each single channel receives at most one key every two cycles.
- `halt` at cycle t: `busy` = 0 and `halted` = 1 from t+1. `gnt` is 0 at t+1.
- Grant of `KEY_UPPER` at cycle t+1: `last_o` = 1 in that cycle, and `exhausted` = 1 in the same cycle.
- `KEY_LOWER == KEY_UPPER`: exactly one key is issued, with `last_o` = 1.

## Test plan

1. Reset, then `start` high with `req = 4'b0001` held; `KEY_LOWER = 0`, `KEY_UPPER = 5`.
   - Grants on every other cycle carrying keys 0 to 5.
   - `last_o` and `exhausted` = 1 with key 5.
   - `gnt` = 0 thereafter.
2. All four `req` high continuously.
   - Grants rotate through channels 0, 1, 2, 3, 0, … with keys 0, 1, 2, 3, 4, ….
   - No key is repeated and none is skipped.
3. `halt` asserted in the same cycle as a pending `req`.
   - No grant is issued; `halted` = 1 next cycle.
   - A later `start` edge restarts the sweep with key 0 to channel 0.
4. `reset` pulsed mid-sweep after key 3 was issued.
   - All outputs are 0 and the state is IDLE.
   - After a new `start`, the first key is 0.
5. `KEY_LOWER = KEY_UPPER = 24'hFFFFFF`, `req` high.
   - Single grant with `key_o = FFFFFF` and `last_o` = 1; no wrap to 0.
6. `start` held high through reset release and then kept high.
   - Exactly one `start_edge`; the sweep runs once.
   - `exhausted` stays high with no restart until `start` toggles.
